// File: rtl/uart_mon_pkg.sv
// Shared types, constants and helpers for the UART receive monitor.
package uart_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } uart_mon_state_t;

   // End-of-transmission byte (ASCII EOT)
   localparam logic [7:0] UART_MON_EOT = 8'h04;

   // Clock cycles per bit, truncated
   function automatic int uart_mon_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// Synchronous show-ahead FIFO. The head entry is presented combinationally
// and reads as zero while empty. A push into a full FIFO is still accepted
// when a pop happens in the same cycle.
module uart_mon_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              do_pop;
   logic              do_push;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

   // Pointer advance for accepted pushes and pops
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers; only these carry reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents are never read while empty so need no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO with valid/ready output,
// framing-error pulse and sticky overflow flag.
// Optional macro UART_MON_EOT_EN adds o_done, a sticky flag set when the
// byte 0x04 is pushed.
module uart_rx_monitor
   import uart_mon_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 25000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overflow
`ifdef UART_MON_EOT_EN
   ,
   output logic       o_done
`endif
);

   localparam int          DIV     = uart_mon_div(CLK_FREQ_HZ, BAUD_RATE);
   localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
   localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

   if (DIV < 4) begin : g_bad_div
      $error("uart_rx_monitor: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_rx_monitor: FIFO_DEPTH must be a power of two >= 2");
   end

   uart_mon_state_t state_q, state_d;
   logic [1:0]      sync_q, sync_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [2:0]      bitidx_q, bitidx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            frame_err_q, frame_err_d;
   logic            overflow_q, overflow_d;
   logic            rxs;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;

   assign rxs = sync_q[1];

   // Receive FSM: bit timing, sampling, shift and push/error decisions
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitidx_d    = bitidx_q;
      shreg_d     = shreg_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rxs) begin
               cnt_d   = HALF_M1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (rxs) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d    = DIV_M1;
               bitidx_d = 3'd0;
               state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               shreg_d  = {rxs, shreg_q[7:1]};
               cnt_d    = DIV_M1;
               bitidx_d = bitidx_q + 3'd1;
               if (bitidx_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (rxs) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               frame_err_d = 1'b1;
               state_d     = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            if (rxs) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pop        = ~fifo_empty & i_ready;
   assign sync_d     = {sync_q[0], i_rx};
   assign overflow_d = overflow_q | (push & fifo_full & ~pop);

   // Control registers; the shift register is datapath and not reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sync_q      <= 2'b11;
         cnt_q       <= '0;
         bitidx_q    <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         bitidx_q    <= bitidx_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   // Shift register update
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   uart_mon_fifo #(
      .DATA_W (8),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (shreg_q),
      .pop   (i_ready),
      .rdata (o_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign o_valid     = ~fifo_empty;
   assign o_frame_err = frame_err_q;
   assign o_overflow  = overflow_q;

`ifdef UART_MON_EOT_EN
   logic done_q, done_d;

   assign done_d = done_q | (push & (shreg_q == UART_MON_EOT));
   assign o_done = done_q;

   // Sticky end-of-transmission flag
   always_ff @(posedge clk) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= done_d;
   end
`endif

endmodule
